// File: rtl/wb_pkg.sv
// Shared types and helpers for the write-back stage: source-select encoding,
// load byte-lane masks and load-data formatting.
package wb_pkg;

  typedef enum logic [1:0] {
    WB_ALU = 2'b00,
    WB_MEM = 2'b01,
    WB_PC4 = 2'b10,
    WB_RSV = 2'b11
  } wb_sel_t;

  localparam logic [3:0] MASK_W  = 4'b1111;
  localparam logic [3:0] MASK_H0 = 4'b0011;
  localparam logic [3:0] MASK_H1 = 4'b1100;
  localparam logic [3:0] MASK_B0 = 4'b0001;
  localparam logic [3:0] MASK_B1 = 4'b0010;
  localparam logic [3:0] MASK_B2 = 4'b0100;
  localparam logic [3:0] MASK_B3 = 4'b1000;

  // Lane selection follows the address offset, not the mask bits; unknown
  // masks fall back to the full word.
  function automatic logic [31:0] format_load(
    input logic [31:0] word,
    input logic [3:0]  mask,
    input logic [1:0]  off,
    input logic        unsigned_ld
  );
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] res;
    byte_v = word[8*off +: 8];
    half_v = word[16*off[1] +: 16];
    case (mask)
      MASK_B0, MASK_B1, MASK_B2, MASK_B3:
        res = unsigned_ld ? {24'b0, byte_v} : {{24{byte_v[7]}}, byte_v};
      MASK_H0, MASK_H1:
        res = unsigned_ld ? {16'b0, half_v} : {{16{half_v[15]}}, half_v};
      default:
        res = word;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/wb_regfile_unit_regfile_2r1w.sv
// Architectural register file: two combinational read ports with write-first
// bypass, one synchronous write port, x0 hardwired to zero.
module regfile_2r1w
  import wb_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned REG_NUM = 32,
  parameter int unsigned AW      = $clog2(REG_NUM)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [AW-1:0]   raddr1,
  input  logic [AW-1:0]   raddr2,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2
);

  logic [XLEN-1:0] regs [REG_NUM];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < REG_NUM; i++) begin
        regs[i] <= '0;
      end
    end else if (we && (waddr != '0)) begin
      regs[waddr] <= wdata;
    end
  end

  // Bypass lets ID see the value being retired this cycle without a stall.
  always_comb begin
    rdata1 = regs[raddr1];
    if (raddr1 == '0) begin
      rdata1 = '0;
    end else if (we && (raddr1 == waddr)) begin
      rdata1 = wdata;
    end
  end

  always_comb begin
    rdata2 = regs[raddr2];
    if (raddr2 == '0) begin
      rdata2 = '0;
    end else if (we && (raddr2 == waddr)) begin
      rdata2 = wdata;
    end
  end

endmodule

// File: rtl/wb_regfile_unit.sv
// RV32 write-back stage: load formatting, write-back select, register file
// and the cycle / instret counters consumed by the CSR unit.
module wb_regfile_unit
  import wb_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned REG_NUM = 32,
  parameter int unsigned CNT_W   = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wb_NoP_en,
  input  logic             wb_RegWEn,
  input  logic [1:0]       wb_WBSel,
  input  logic [4:0]       wb_rd,
  input  logic [XLEN-1:0]  wb_ALU_out,
  input  logic [XLEN-1:0]  wb_ReadData,
  input  logic [3:0]       wb_REB_dm,
  input  logic             wb_Read_Un,
  input  logic [XLEN-1:0]  wb_pc,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  output logic [XLEN-1:0]  id_rs1_data,
  output logic [XLEN-1:0]  id_rs2_data,
  output logic [XLEN-1:0]  wb_wdata,
  output logic             wb_we,
  output logic [CNT_W-1:0] csr_cycle,
  output logic [CNT_W-1:0] csr_instret
);

  logic [XLEN-1:0] load_data;
  wb_sel_t         wb_sel;

  assign wb_sel    = wb_sel_t'(wb_WBSel);
  assign load_data = format_load(wb_ReadData, wb_REB_dm, wb_ALU_out[1:0], wb_Read_Un);

  always_comb begin
    wb_wdata = wb_ALU_out;
    case (wb_sel)
      WB_ALU:  wb_wdata = wb_ALU_out;
      WB_MEM:  wb_wdata = load_data;
      WB_PC4:  wb_wdata = wb_pc + XLEN'(4);
      default: wb_wdata = wb_ALU_out;
    endcase
  end

  assign wb_we = wb_RegWEn & ~wb_NoP_en & (wb_rd != '0);

  regfile_2r1w #(
    .XLEN    (XLEN),
    .REG_NUM (REG_NUM),
    .AW      (5)
  ) u_regfile (
    .clk    (clk),
    .rst    (rst),
    .we     (wb_we),
    .waddr  (wb_rd),
    .wdata  (wb_wdata),
    .raddr1 (id_rs1),
    .raddr2 (id_rs2),
    .rdata1 (id_rs1_data),
    .rdata2 (id_rs2_data)
  );

  // Any non-bubble retires, including stores, branches and writes to x0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      csr_cycle   <= '0;
      csr_instret <= '0;
    end else begin
      csr_cycle <= csr_cycle + CNT_W'(1);
      if (!wb_NoP_en) begin
        csr_instret <= csr_instret + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_wb_regfile_unit.sv
// Scoreboard bench for wb_regfile_unit: directed scenarios plus random traffic
// checked against an array-based architectural model.
module tb_wb_regfile_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        nop, regwen, un;
  logic [1:0]  sel;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] alu, rdata, pc;
  logic [3:0]  mask;
  logic [31:0] rs1_data, rs2_data, wdata;
  logic        we;
  logic [63:0] cycle, instret;

  always #5 clk = ~clk;

  wb_regfile_unit #(.XLEN(32), .REG_NUM(32), .CNT_W(64)) dut (
    .clk(clk), .rst(rst), .wb_NoP_en(nop), .wb_RegWEn(regwen), .wb_WBSel(sel),
    .wb_rd(rd), .wb_ALU_out(alu), .wb_ReadData(rdata), .wb_REB_dm(mask),
    .wb_Read_Un(un), .wb_pc(pc), .id_rs1(rs1), .id_rs2(rs2),
    .id_rs1_data(rs1_data), .id_rs2_data(rs2_data), .wb_wdata(wdata),
    .wb_we(we), .csr_cycle(cycle), .csr_instret(instret)
  );

  typedef struct {
    int          id;
    logic        we;
    logic [31:0] wd, r1, r2;
    logic [63:0] cyc, ins;
  } exp_t;

  exp_t        q[$];
  int          tests = 0;
  int          failed = 0;
  int          next_id = 0;

  logic [31:0] mregs [32];
  logic [63:0] mcyc, mins;
  logic        p_nop, p_we;
  logic [4:0]  p_rd;
  logic [31:0] p_wd;

  function automatic logic [31:0] ref_load(logic [31:0] w, logic [3:0] m, logic [1:0] o, logic u);
    logic [31:0] v;
    if (m inside {4'd1, 4'd2, 4'd4, 4'd8}) begin
      v = (w >> (8 * o)) & 32'h0000_00FF;
      if (!u && v[7]) v = v | 32'hFFFF_FF00;
    end else if (m inside {4'd3, 4'd12}) begin
      v = (w >> (o[1] ? 16 : 0)) & 32'h0000_FFFF;
      if (!u && v[15]) v = v | 32'hFFFF_0000;
    end else begin
      v = w;
    end
    return v;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) mregs[i] = '0;
    mcyc = '0; mins = '0;
    p_nop = 1'b1; p_we = 1'b0; p_rd = '0; p_wd = '0;
  endtask

  // Expected combinational view of the current inputs against the model state.
  task automatic expect_now();
    exp_t e;
    logic [31:0] v;
    case (sel)
      2'd1:    v = ref_load(rdata, mask, alu[1:0], un);
      2'd2:    v = pc + 32'd4;
      default: v = alu;
    endcase
    e.id  = next_id++;
    e.we  = regwen && !nop && (rd != 0);
    e.wd  = v;
    e.r1  = (rs1 == 0) ? 32'd0 : ((e.we && rs1 == rd) ? v : mregs[rs1]);
    e.r2  = (rs2 == 0) ? 32'd0 : ((e.we && rs2 == rd) ? v : mregs[rs2]);
    e.cyc = mcyc;
    e.ins = mins;
    q.push_back(e);
    p_nop = nop; p_we = e.we; p_rd = rd; p_wd = v;
  endtask

  task automatic advance();
    @(posedge clk);
    if (!rst) begin
      mcyc++;
      if (!p_nop) mins++;
      if (p_we) mregs[p_rd] = p_wd;
    end
    #1;
  endtask

  task automatic step(input logic n, input logic w, input logic [1:0] s, input logic [4:0] d,
                      input logic [31:0] a, input logic [31:0] rdw, input logic [3:0] m,
                      input logic u, input logic [31:0] p, input logic [4:0] r1, input logic [4:0] r2);
    nop = n; regwen = w; sel = s; rd = d; alu = a; rdata = rdw; mask = m; un = u; pc = p;
    rs1 = r1; rs2 = r2;
    expect_now();
    advance();
  endtask

  task automatic do_reset(input logic [4:0] r1, input logic [4:0] r2);
    rst = 1'b1; nop = 1'b1; regwen = 1'b0; sel = 2'd0; alu = '0; rs1 = r1; rs2 = r2;
    model_clear();
    expect_now();
    @(posedge clk);
    #1;
    rst = 1'b0;
    expect_now();
    advance();
  endtask

  task automatic chk(input string name, input int id, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s #%0d: got %h expected %h", name, id, act, exp);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("wb_we", e.id, {63'd0, we}, {63'd0, e.we});
        chk("wb_wdata", e.id, {32'd0, wdata}, {32'd0, e.wd});
        chk("rs1_data", e.id, {32'd0, rs1_data}, {32'd0, e.r1});
        chk("rs2_data", e.id, {32'd0, rs2_data}, {32'd0, e.r2});
        chk("csr_cycle", e.id, cycle, e.cyc);
        chk("csr_instret", e.id, instret, e.ins);
      end
    end
  end

  initial begin : driver
    logic [3:0]  masks [8];
    logic [4:0]  rr;
    masks = '{4'hF, 4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hC, 4'h5};
    rst = 1'b1; nop = 1'b1; regwen = 1'b0; sel = '0; rd = '0; alu = '0; rdata = '0;
    mask = 4'hF; un = 1'b0; pc = '0; rs1 = '0; rs2 = '0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 1; i < 32; i++)
      step(1'b1, 1'b1, 2'd0, 5'(i), $urandom, $urandom, 4'hF, 1'b0, $urandom, 5'(i), 5'(32 - i));

    step(1'b0, 1'b1, 2'd1, 5'd5, 32'h0000_0002, 32'h80FF_7F01, 4'b0100, 1'b0, 32'h0, 5'd5, 5'd0);
    step(1'b0, 1'b1, 2'd1, 5'd6, 32'h0000_0002, 32'h80FF_7F01, 4'b1100, 1'b1, 32'h0, 5'd5, 5'd6);
    step(1'b0, 1'b1, 2'd0, 5'd7, 32'h1234_5678, 32'h0, 4'hF, 1'b0, 32'h0, 5'd7, 5'd7);
    step(1'b1, 1'b0, 2'd0, 5'd0, 32'h0, 32'h0, 4'hF, 1'b0, 32'h0, 5'd6, 5'd7);
    step(1'b0, 1'b1, 2'd0, 5'd3, 32'h0000_0333, 32'h0, 4'hF, 1'b0, 32'h0, 5'd3, 5'd0);
    step(1'b0, 1'b1, 2'd0, 5'd0, 32'hDEAD_BEEF, 32'h0, 4'hF, 1'b0, 32'h0, 5'd0, 5'd3);
    step(1'b1, 1'b1, 2'd0, 5'd3, 32'hCAFE_0003, 32'h0, 4'hF, 1'b0, 32'h0, 5'd3, 5'd0);
    step(1'b1, 1'b0, 2'd0, 5'd0, 32'h0, 32'h0, 4'hF, 1'b0, 32'h0, 5'd3, 5'd0);

    step(1'b0, 1'b1, 2'd0, 5'd1, 32'h0000_0055, 32'h0, 4'hF, 1'b0, 32'h0, 5'd1, 5'd0);
    step(1'b0, 1'b1, 2'd2, 5'd1, 32'h0000_0077, 32'h0, 4'hF, 1'b0, 32'hFFFF_FFFC, 5'd1, 5'd1);
    step(1'b0, 1'b1, 2'd0, 5'd2, 32'hA5A5_A5A5, 32'h0, 4'hF, 1'b0, 32'h0, 5'd1, 5'd2);
    do_reset(5'd2, 5'd5);
    step(1'b1, 1'b0, 2'd0, 5'd0, 32'h0, 32'h0, 4'hF, 1'b0, 32'h0, 5'd2, 5'd7);

    for (int n = 0; n < 600; n++) begin
      rr = 5'($urandom_range(0, 31));
      if (n == 300) do_reset(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
      step(($urandom_range(0, 3) == 0), ($urandom_range(0, 4) != 0), 2'($urandom_range(0, 3)), rr,
           $urandom, $urandom, masks[$urandom_range(0, 7)], 1'($urandom), $urandom,
           ($urandom_range(0, 2) == 0) ? rr : 5'($urandom_range(0, 31)),
           ($urandom_range(0, 2) == 0) ? rr : 5'($urandom_range(0, 31)));
    end

    for (int k = 0; k < 10 && q.size() > 0; k++) @(posedge clk);
    if (q.size() > 0) begin
      failed++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
